// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: A - B - bin, one bit per clock LSB first, through a
// single full-subtractor cell and a borrow flop, with valid/ready on both sides.
module serial_subtractor #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] diff,
   output logic             bout,
   output logic             ovf,
   output logic             busy
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] a_sh, b_sh, res;
   logic [CW-1:0]    cnt;
   logic             br;
   logic             a_msb, b_msb;

   // full-subtractor cell on the current LSBs
   logic             a0, b0, d, br_nxt, last, accept;
   logic [WIDTH-1:0] res_nxt;

   assign a0      = a_sh[0];
   assign b0      = b_sh[0];
   assign d       = a0 ^ b0 ^ br;
   assign br_nxt  = (~a0 & b0) | (~(a0 ^ b0) & br);
   assign res_nxt = {d, res[WIDTH-1:1]};
   assign last    = (cnt == CW'(WIDTH - 1));
   assign accept  = (state == IDLE) && in_valid;

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign busy      = (state != IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (in_valid)  state_nxt = SHIFT;
         SHIFT:   if (last)      state_nxt = DONE;
         DONE:    if (out_ready) state_nxt = IDLE;
         default:                state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sh  <= '0;
         b_sh  <= '0;
         res   <= '0;
         cnt   <= '0;
         br    <= 1'b0;
         a_msb <= 1'b0;
         b_msb <= 1'b0;
         diff  <= '0;
         bout  <= 1'b0;
         ovf   <= 1'b0;
      end else if (accept) begin
         a_sh  <= a;
         b_sh  <= b;
         br    <= bin;
         a_msb <= a[WIDTH-1];
         b_msb <= b[WIDTH-1];
         cnt   <= '0;
      end else if (state == SHIFT) begin
         res  <= res_nxt;
         br   <= br_nxt;
         a_sh <= a_sh >> 1;
         b_sh <= b_sh >> 1;
         cnt  <= cnt + 1'b1;
         // result registers update only once the full word has been formed
         if (last) begin
            diff <= res_nxt;
            bout <= br_nxt;
            ovf  <= (a_msb != b_msb) && (res_nxt[WIDTH-1] != a_msb);
         end
      end
   end

endmodule
